// File: rtl/core_regfile_pkg.sv
// rtl/core_regfile_pkg.sv - shared widths, bank encoding and register address type for core_regfile
package core_regfile_pkg;
  localparam int REG_IDX_W = 5;
  localparam int XLEN      = 32;
  localparam int NUM_REGS  = 32;

  localparam logic BANK_INT = 1'b0;
  localparam logic BANK_FP  = 1'b1;

  typedef struct packed {
    logic                 bank;
    logic [REG_IDX_W-1:0] idx;
  } reg_addr_t;

  // Integer x0 is hardwired to zero; float f0 is an ordinary register.
  function automatic logic is_zero_reg(input reg_addr_t a);
    return (a.bank == BANK_INT) && (a.idx == '0);
  endfunction

  function automatic logic [REG_IDX_W:0] flat_idx(input reg_addr_t a);
    return {a.bank, a.idx};
  endfunction
endpackage

// File: rtl/core_scoreboard.sv
// rtl/core_scoreboard.sv - 64-entry busy scoreboard, mark beats clear, three combinational lookups
module core_scoreboard
  import core_regfile_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            mark,
  input  reg_addr_t       mark_addr,
  input  logic            clear,
  input  reg_addr_t       clear_addr,
  input  reg_addr_t [2:0] lookup,
  output logic      [2:0] busy
);
  logic [2*NUM_REGS-1:0] busy_bits;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_bits <= '0;
    end else begin
      if (clear) busy_bits[flat_idx(clear_addr)] <= 1'b0;
      // Later assignment wins, so a same-register mark overrides the clear.
      if (mark && !is_zero_reg(mark_addr)) busy_bits[flat_idx(mark_addr)] <= 1'b1;
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < 3; i++) busy[i] = busy_bits[flat_idx(lookup[i])];
  end
endmodule

// File: rtl/core_regfile.sv
// rtl/core_regfile.sv - integer/float register files, PC and busy scoreboard
// Optional same-cycle write-to-read bypass: CORE_REGFILE_BYPASS_EN
module core_regfile
  import core_regfile_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wenable,
  input  logic                 fmode,
  input  logic [REG_IDX_W-1:0] wreg,
  input  logic [XLEN-1:0]      wdata,
  input  logic                 pcenable,
  input  logic [XLEN-1:0]      next_pc,
  output logic [XLEN-1:0]      pc,
  input  logic                 renable,
  input  logic [REG_IDX_W-1:0] rs1,
  input  logic [REG_IDX_W-1:0] rs2,
  input  logic [REG_IDX_W-1:0] rs3,
  input  logic                 rs1_f,
  input  logic                 rs2_f,
  input  logic                 rs3_f,
  output logic [XLEN-1:0]      rdata1,
  output logic [XLEN-1:0]      rdata2,
  output logic [XLEN-1:0]      rdata3,
  output logic                 rvalid,
  input  logic                 mark,
  input  logic [REG_IDX_W-1:0] mark_rd,
  input  logic                 mark_f,
  output logic                 busy1,
  output logic                 busy2,
  output logic                 busy3
);
  logic [XLEN-1:0] int_regs [NUM_REGS];
  logic [XLEN-1:0] fp_regs  [NUM_REGS];
  logic [XLEN-1:0] rd_next  [3];
  reg_addr_t [2:0] rd_addr;
  reg_addr_t       waddr;
  logic [2:0]      busy;

  assign waddr      = {fmode, wreg};
  assign rd_addr[0] = {rs1_f, rs1};
  assign rd_addr[1] = {rs2_f, rs2};
  assign rd_addr[2] = {rs3_f, rs3};

  function automatic logic [XLEN-1:0] read_reg(input reg_addr_t a);
    if (is_zero_reg(a)) return '0;
    return (a.bank == BANK_FP) ? fp_regs[a.idx] : int_regs[a.idx];
  endfunction

  always_comb begin
    for (int i = 0; i < 3; i++) begin
`ifdef CORE_REGFILE_BYPASS_EN
      rd_next[i] = (wenable && rd_addr[i] == waddr && !is_zero_reg(waddr)) ? wdata
                                                                           : read_reg(rd_addr[i]);
`else
      rd_next[i] = read_reg(rd_addr[i]);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        int_regs[i] <= '0;
        fp_regs[i]  <= '0;
      end
      pc <= RESET_PC;
    end else begin
      if (wenable && !is_zero_reg(waddr)) begin
        if (fmode == BANK_FP) fp_regs[wreg] <= wdata;
        else                  int_regs[wreg] <= wdata;
      end
      if (pcenable) pc <= next_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata1 <= '0;
      rdata2 <= '0;
      rdata3 <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= renable;
      if (renable) begin
        rdata1 <= rd_next[0];
        rdata2 <= rd_next[1];
        rdata3 <= rd_next[2];
      end
    end
  end

  core_scoreboard u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .mark       (mark),
    .mark_addr  ({mark_f, mark_rd}),
    .clear      (wenable),
    .clear_addr (waddr),
    .lookup     (rd_addr),
    .busy       (busy)
  );

  assign busy1 = busy[0];
  assign busy2 = busy[1];
  assign busy3 = busy[2];
endmodule

// File: tb/tb_core_regfile.sv
// tb/tb_core_regfile.sv - directed vector table plus randomized run against a behavioural model
module tb_core_regfile;
  localparam logic [31:0] RPC = 32'h0000_1000;
`ifdef CORE_REGFILE_BYPASS_EN
  localparam logic [31:0] SAME_CYCLE_X7 = 32'h55;
`else
  localparam logic [31:0] SAME_CYCLE_X7 = 32'h11;
`endif

  logic clk = 1'b0;
  logic rst, wenable, fmode, pcenable, renable, mark, mark_f;
  logic rs1_f, rs2_f, rs3_f;
  logic [4:0] wreg, rs1, rs2, rs3, mark_rd;
  logic [31:0] wdata, next_pc, pc, rdata1, rdata2, rdata3;
  logic rvalid, busy1, busy2, busy3;

  int total = 0;
  int bad = 0;

  // Behavioural model of the architectural state
  logic [31:0] m_int [32];
  logic [31:0] m_fp  [32];
  bit   [31:0] m_bi, m_bf;
  logic [31:0] m_pc, m_rd [3];
  logic        m_rv;

  always #5 clk = ~clk;

  core_regfile #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .wenable(wenable), .fmode(fmode), .wreg(wreg), .wdata(wdata),
    .pcenable(pcenable), .next_pc(next_pc), .pc(pc), .renable(renable),
    .rs1(rs1), .rs2(rs2), .rs3(rs3), .rs1_f(rs1_f), .rs2_f(rs2_f), .rs3_f(rs3_f),
    .rdata1(rdata1), .rdata2(rdata2), .rdata3(rdata3), .rvalid(rvalid),
    .mark(mark), .mark_rd(mark_rd), .mark_f(mark_f),
    .busy1(busy1), .busy2(busy2), .busy3(busy3)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] idx, input logic f);
    if (!f && idx == 0) return 32'h0;
`ifdef CORE_REGFILE_BYPASS_EN
    if (wenable && fmode == f && wreg == idx) return wdata;
`endif
    return f ? m_fp[idx] : m_int[idx];
  endfunction

  function automatic bit m_busy(input logic [4:0] idx, input logic f);
    return f ? m_bf[idx] : m_bi[idx];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin
      m_int[i] = '0;
      m_fp[i]  = '0;
    end
    m_bi = '0; m_bf = '0; m_pc = RPC; m_rv = 1'b0;
    for (int i = 0; i < 3; i++) m_rd[i] = '0;
  endtask

  // Inputs are already applied; check pre-edge busy, advance model, check post-edge outputs.
  task automatic cycle();
    logic [31:0] nrd [3];
    #1;
    chk("busy1_pre", {31'b0, busy1}, {31'b0, m_busy(rs1, rs1_f)});
    chk("busy2_pre", {31'b0, busy2}, {31'b0, m_busy(rs2, rs2_f)});
    chk("busy3_pre", {31'b0, busy3}, {31'b0, m_busy(rs3, rs3_f)});
    nrd[0] = m_read(rs1, rs1_f);
    nrd[1] = m_read(rs2, rs2_f);
    nrd[2] = m_read(rs3, rs3_f);
    if (rst) begin
      m_reset();
    end else begin
      if (renable) for (int i = 0; i < 3; i++) m_rd[i] = nrd[i];
      m_rv = renable;
      if (wenable && !(fmode == 1'b0 && wreg == 0)) begin
        if (fmode) m_fp[wreg] = wdata;
        else       m_int[wreg] = wdata;
      end
      if (wenable) begin
        if (fmode) m_bf[wreg] = 1'b0;
        else       m_bi[wreg] = 1'b0;
      end
      if (mark && !(mark_f == 1'b0 && mark_rd == 0)) begin
        if (mark_f) m_bf[mark_rd] = 1'b1;
        else        m_bi[mark_rd] = 1'b1;
      end
      if (pcenable) m_pc = next_pc;
    end
    @(posedge clk);
    #1;
    chk("pc", pc, m_pc);
    chk("rvalid", {31'b0, rvalid}, {31'b0, m_rv});
    chk("rdata1", rdata1, m_rd[0]);
    chk("rdata2", rdata2, m_rd[1]);
    chk("rdata3", rdata3, m_rd[2]);
  endtask

  typedef struct {
    logic rst, wen, fm; logic [4:0] wreg; logic [31:0] wdata;
    logic pcen; logic [31:0] npc;
    logic ren; logic [4:0] r1; logic f1; logic [4:0] r2; logic f2;
    logic mk; logic [4:0] mrd; logic mf;
    logic [31:0] e_pc; logic e_rv; logic [31:0] e_rd1, e_rd2; logic e_busy1;
  } vec_t;

  vec_t vecs [21];

  initial begin
    //          rst wen fm wreg wdata          pcen npc         ren r1 f1 r2 f2 mk mrd mf  e_pc  rv e_rd1         e_rd2         busy1
    vecs[0]  = '{1, 1, 0, 3, 32'hAA,          1, 32'h80,   1, 9, 0, 0, 0, 1, 9, 0, RPC, 0, 32'h0,        32'h0,        0};
    vecs[1]  = '{0, 0, 0, 0, 32'h0,           0, 32'h0,    1, 5, 0, 5, 1, 0, 0, 0, RPC, 1, 32'h0,        32'h0,        0};
    vecs[2]  = '{0, 1, 0, 3, 32'hDEAD_BEEF,   0, 32'h0,    0, 3, 0, 3, 1, 0, 0, 0, RPC, 0, 32'h0,        32'h0,        0};
    vecs[3]  = '{0, 1, 1, 3, 32'h3F80_0000,   0, 32'h0,    0, 3, 0, 3, 1, 0, 0, 0, RPC, 0, 32'h0,        32'h0,        0};
    vecs[4]  = '{0, 0, 0, 0, 32'h0,           0, 32'h0,    1, 3, 0, 3, 1, 0, 0, 0, RPC, 1, 32'hDEAD_BEEF, 32'h3F80_0000, 0};
    vecs[5]  = '{0, 0, 0, 0, 32'h0,           0, 32'h0,    0, 0, 0, 0, 1, 0, 0, 0, RPC, 0, 32'hDEAD_BEEF, 32'h3F80_0000, 0};
    vecs[6]  = '{0, 1, 0, 0, 32'hFFFF_FFFF,   0, 32'h0,    0, 0, 0, 0, 1, 0, 0, 0, RPC, 0, 32'hDEAD_BEEF, 32'h3F80_0000, 0};
    vecs[7]  = '{0, 1, 1, 0, 32'h1,           0, 32'h0,    0, 0, 0, 0, 1, 0, 0, 0, RPC, 0, 32'hDEAD_BEEF, 32'h3F80_0000, 0};
    vecs[8]  = '{0, 0, 0, 0, 32'h0,           0, 32'h0,    1, 0, 0, 0, 1, 0, 0, 0, RPC, 1, 32'h0,        32'h1,        0};
    vecs[9]  = '{0, 1, 0, 7, 32'h11,          0, 32'h0,    0, 7, 0, 0, 1, 0, 0, 0, RPC, 0, 32'h0,        32'h1,        0};
    vecs[10] = '{0, 1, 0, 7, 32'h55,          0, 32'h0,    1, 7, 0, 0, 1, 0, 0, 0, RPC, 1, SAME_CYCLE_X7, 32'h1,        0};
    vecs[11] = '{0, 0, 0, 0, 32'h0,           0, 32'h0,    1, 7, 0, 0, 1, 0, 0, 0, RPC, 1, 32'h55,       32'h1,        0};
    vecs[12] = '{0, 0, 0, 0, 32'h0,           0, 32'h0,    0, 9, 0, 0, 1, 1, 9, 0, RPC, 0, 32'h55,       32'h1,        1};
    vecs[13] = '{0, 1, 0, 9, 32'h99,          0, 32'h0,    0, 9, 0, 0, 1, 1, 9, 0, RPC, 0, 32'h55,       32'h1,        1};
    vecs[14] = '{0, 1, 0, 9, 32'h77,          0, 32'h0,    0, 9, 0, 0, 1, 0, 0, 0, RPC, 0, 32'h55,       32'h1,        0};
    vecs[15] = '{0, 0, 0, 0, 32'h0,           0, 32'h0,    0, 0, 0, 0, 1, 1, 0, 0, RPC, 0, 32'h55,       32'h1,        0};
    vecs[16] = '{0, 0, 0, 0, 32'h0,           1, 32'h40,   0, 0, 0, 0, 1, 0, 0, 0, 32'h40, 0, 32'h55,    32'h1,        0};
    vecs[17] = '{0, 0, 0, 0, 32'h0,           0, 32'h123,  0, 0, 0, 0, 1, 0, 0, 0, 32'h40, 0, 32'h55,    32'h1,        0};
    vecs[18] = '{0, 0, 0, 0, 32'h0,           0, 32'h0,    0, 9, 0, 0, 1, 1, 9, 1, 32'h40, 0, 32'h55,    32'h1,        0};
    vecs[19] = '{1, 1, 0, 3, 32'h1,           1, 32'h80,   1, 3, 0, 3, 1, 1, 9, 0, RPC, 0, 32'h0,        32'h0,        0};
    vecs[20] = '{0, 0, 0, 0, 32'h0,           0, 32'h0,    1, 3, 0, 3, 1, 0, 0, 0, RPC, 1, 32'h0,        32'h0,        0};

    rst = 1; wenable = 0; fmode = 0; wreg = 0; wdata = 0; pcenable = 0; next_pc = 0;
    renable = 0; rs1 = 0; rs2 = 0; rs3 = 31; rs1_f = 0; rs2_f = 0; rs3_f = 1;
    mark = 0; mark_rd = 0; mark_f = 0;
    @(posedge clk);
    #1;
    m_reset();

    for (int v = 0; v < 21; v++) begin
      rst = vecs[v].rst; wenable = vecs[v].wen; fmode = vecs[v].fm; wreg = vecs[v].wreg;
      wdata = vecs[v].wdata; pcenable = vecs[v].pcen; next_pc = vecs[v].npc;
      renable = vecs[v].ren; rs1 = vecs[v].r1; rs1_f = vecs[v].f1;
      rs2 = vecs[v].r2; rs2_f = vecs[v].f2; rs3 = 31; rs3_f = 1;
      mark = vecs[v].mk; mark_rd = vecs[v].mrd; mark_f = vecs[v].mf;
      cycle();
      chk($sformatf("v%0d_pc", v), pc, vecs[v].e_pc);
      chk($sformatf("v%0d_rvalid", v), {31'b0, rvalid}, {31'b0, vecs[v].e_rv});
      chk($sformatf("v%0d_rdata1", v), rdata1, vecs[v].e_rd1);
      chk($sformatf("v%0d_rdata2", v), rdata2, vecs[v].e_rd2);
      chk($sformatf("v%0d_busy1", v), {31'b0, busy1}, {31'b0, vecs[v].e_busy1});
    end

    // Small index range keeps write/read/mark collisions frequent.
    for (int n = 0; n < 600; n++) begin
      rst      = ($urandom_range(63) == 0);
      wenable  = $urandom_range(1);
      fmode    = $urandom_range(1);
      wreg     = 5'($urandom_range(7));
      wdata    = $urandom;
      pcenable = ($urandom_range(3) == 0);
      next_pc  = $urandom;
      renable  = $urandom_range(1);
      rs1 = 5'($urandom_range(7)); rs1_f = $urandom_range(1);
      rs2 = 5'($urandom_range(7)); rs2_f = $urandom_range(1);
      rs3 = 5'($urandom_range(7)); rs3_f = $urandom_range(1);
      mark     = $urandom_range(1);
      mark_rd  = 5'($urandom_range(7));
      mark_f   = $urandom_range(1);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
